// File: rtl/write_buffer_if.sv
// Write-buffer bus: cache write/lookup side plus the memory drain port.
// DEPTH sets the width of the occupancy count.
interface write_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wrReq;
  logic [31:0]   wrAdd;
  logic [31:0]   wrData;
  logic          wrAck;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          rdReq;
  logic [31:0]   rdAdd;
  logic          rdHit;
  logic [31:0]   rdData;
  logic          memWe;
  logic [31:0]   memAdd;
  logic [31:0]   memData;
  logic          memReady;

  modport slave (
    input  wrReq, wrAdd, wrData, rdReq, rdAdd, memReady,
    output wrAck, full, empty, count, rdHit, rdData, memWe, memAdd, memData
  );

  modport master (
    output wrReq, wrAdd, wrData, rdReq, rdAdd, memReady,
    input  wrAck, full, empty, count, rdHit, rdData, memWe, memAdd, memData
  );
endinterface

// File: rtl/write_buffer.sv
// Circular write-through buffer with read-miss forwarding and a two-state drain FSM.
// Define WB_COALESCE_EN to merge writes to a buffered word instead of allocating.
module write_buffer #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_full, r_empty;
  logic          r_rd_hit;
  logic [31:0]   r_rd_data;
  logic [31:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] w_ord  [DEPTH];
  logic          w_wr_ack, w_push, w_pop, w_coal, w_lk_hit;
  logic [PW-1:0] w_coal_idx;
  logic [31:0]   w_lk_data;
  logic          w_unused;

  assign w_unused = ^bus.rdAdd[1:0];

  // w_ord[k] is the slot holding the k-th oldest entry
  always_comb begin
    for (int k = 0; k < DEPTH; k++) w_ord[k] = r_head + PW'(k);
  end

`ifdef WB_COALESCE_EN
  // The head being drained must stay stable, so it never absorbs a write
  always_comb begin
    w_coal     = 1'b0;
    w_coal_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < r_count && r_addr[w_ord[k]][31:2] == bus.wrAdd[31:2] &&
          !(k == 0 && r_state == DRAIN)) begin
        w_coal     = 1'b1;
        w_coal_idx = w_ord[k];
      end
    end
  end
`else
  assign w_coal     = 1'b0;
  assign w_coal_idx = '0;
`endif

  assign w_wr_ack    = bus.wrReq & (~r_full | w_coal);
  assign w_push      = w_wr_ack & ~w_coal;
  assign w_pop       = (r_state == DRAIN) & bus.memReady;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // Scan oldest to newest so the newest match wins; a same-cycle write beats all.
  // Uses pre-pop occupancy, so an entry leaving this cycle still matches.
  always_comb begin
    w_lk_hit  = 1'b0;
    w_lk_data = r_rd_data;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < r_count && r_addr[w_ord[k]][31:2] == bus.rdAdd[31:2]) begin
        w_lk_hit  = 1'b1;
        w_lk_data = r_data[w_ord[k]];
      end
    end
    if (w_wr_ack && bus.wrAdd[31:2] == bus.rdAdd[31:2]) begin
      w_lk_hit  = 1'b1;
      w_lk_data = bus.wrData;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (!r_empty) w_state_nxt = DRAIN;
      DRAIN: if (w_pop && w_count_nxt == '0) w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_rd_hit  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == CW'(DEPTH));
      r_empty  <= (w_count_nxt == '0);
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      r_rd_hit <= bus.rdReq & w_lk_hit;
      if (bus.rdReq && w_lk_hit) r_rd_data <= w_lk_data;
    end
  end

  // Entry storage needs no reset: occupancy decides what is valid
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= bus.wrAdd;
      r_data[r_tail] <= bus.wrData;
    end else if (w_wr_ack && w_coal) begin
      r_data[w_coal_idx] <= bus.wrData;
    end
  end

  assign bus.wrAck   = w_wr_ack;
  assign bus.full    = r_full;
  assign bus.empty   = r_empty;
  assign bus.count   = r_count;
  assign bus.rdHit   = r_rd_hit;
  assign bus.rdData  = r_rd_data;
  assign bus.memWe   = (r_state == DRAIN);
  assign bus.memAdd  = (r_state == DRAIN) ? r_addr[r_head] : '0;
  assign bus.memData = (r_state == DRAIN) ? r_data[r_head] : '0;
endmodule

// File: tb/tb_write_buffer.sv
// Scoreboarded bench for write_buffer: memory writes and lookup responses are
// checked by monitors against queues filled by the directed stimulus.
module tb_write_buffer;
  localparam int DEPTH = 4;

  typedef struct {
    logic        hit;
    logic [31:0] data;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  write_buffer_if #(.DEPTH(DEPTH)) bus ();
  write_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_xfer = 0;
  logic [63:0] mem_q [$];
  rd_exp_t     rd_q  [$];
  logic        pend  = 1'b0;
  logic [31:0] hold  = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic exp_mem(input logic [31:0] a, input logic [31:0] d);
    mem_q.push_back({a, d});
  endtask

  task automatic exp_rd(input logic h, input logic [31:0] d);
    rd_exp_t e;
    e.hit  = h;
    e.data = d;
    rd_q.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.wrReq  = 1'b1;
    bus.wrAdd  = a;
    bus.wrData = d;
    neg();
    chk("wrAck", bus.wrAck, 1);
    step();
    bus.wrReq = 1'b0;
  endtask

  task automatic drain();
    logic done;
    bus.memReady = 1'b1;
    for (int i = 0; i < 40 && !(bus.empty && !bus.memWe); i++) step();
    done = bus.empty && !bus.memWe;
    chk("drain_done", done, 1);
    bus.memReady = 1'b0;
  endtask

  // Memory-side monitor: a transfer completes on each edge with memWe & memReady
  always @(negedge clk) begin
    if (rst) begin
      mem_q.delete();
    end else if (bus.memWe && bus.memReady) begin
      logic [63:0] e;
      n_xfer++;
      if (mem_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL mem_xfer: unexpected write %0h/%0h, expected none", bus.memAdd, bus.memData);
      end else begin
        e = mem_q.pop_front();
        chk("memAdd", bus.memAdd, e[63:32]);
        chk("memData", bus.memData, e[31:0]);
      end
    end
  end

  // Lookup monitor: response is due one cycle after rdReq
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
      hold = '0;
    end else begin
      if (pend) begin
        if (rd_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rd_resp: response %0b/%0h, expected none", bus.rdHit, bus.rdData);
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          chk("rdHit", bus.rdHit, e.hit);
          if (e.hit) hold = e.data;
          chk("rdData", bus.rdData, hold);
        end
      end else begin
        chk("rdHit_idle", bus.rdHit, 0);
      end
      pend = bus.rdReq;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    bus.wrReq = 0; bus.wrAdd = 0; bus.wrData = 0;
    bus.rdReq = 0; bus.rdAdd = 0; bus.memReady = 0;

    // Reset state
    step(); step();
    neg();
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_memWe", bus.memWe, 0);
    chk("rst_rdHit", bus.rdHit, 0);
    chk("rst_rdData", bus.rdData, 0);
    chk("rst_memAdd", bus.memAdd, 0);
    chk("rst_memData", bus.memData, 0);
    step();
    rst = 1'b0;

    // Single write, held handshake, then pop
    exp_mem(32'h40, 111);
    wr(32'h40, 111);
    neg();
    chk("t1_count", bus.count, 1);
    chk("t1_empty", bus.empty, 0);
    chk("t1_memWe_idle", bus.memWe, 0);
    step();
    neg();
    chk("t1_memWe", bus.memWe, 1);
    chk("t1_memAdd", bus.memAdd, 32'h40);
    chk("t1_memData", bus.memData, 111);
    step();
    neg();
    chk("t1_memAdd_hold", bus.memAdd, 32'h40);
    step();
    bus.memReady = 1'b1;
    step();
    bus.memReady = 1'b0;
    neg();
    chk("t1_count_pop", bus.count, 0);
    chk("t1_empty_pop", bus.empty, 1);
    chk("t1_memWe_pop", bus.memWe, 0);
    step();

    // Fill to full, refused write, accepted after a pop
    exp_mem(32'h40, 1);   wr(32'h40, 1);
    exp_mem(32'h440, 2);  wr(32'h440, 2);
    exp_mem(32'hC40, 3);  wr(32'hC40, 3);
    exp_mem(32'h1C40, 4); wr(32'h1C40, 4);
    neg();
    chk("t2_count_full", bus.count, 4);
    chk("t2_full", bus.full, 1);
    bus.wrReq = 1'b1; bus.wrAdd = 32'h840; bus.wrData = 5;
    neg();
    chk("t2_refused", bus.wrAck, 0);
    step();
    bus.memReady = 1'b1;
    neg();
    chk("t2_refused_pop", bus.wrAck, 0);
    step();
    bus.memReady = 1'b0;
    neg();
    chk("t2_full_after_pop", bus.full, 0);
    chk("t2_accept", bus.wrAck, 1);
    exp_mem(32'h840, 5);
    step();
    bus.wrReq = 1'b0;
    neg();
    chk("t2_count_refill", bus.count, 4);
    step();
    drain();

    // Newest-match forwarding and word-granular compare
`ifdef WB_COALESCE_EN
    exp_mem(32'h840, 6000);
`else
    exp_mem(32'h840, 5000);
    exp_mem(32'h840, 6000);
`endif
    wr(32'h840, 5000);
    wr(32'h840, 6000);
    neg();
`ifdef WB_COALESCE_EN
    chk("t3_count", bus.count, 1);
`else
    chk("t3_count", bus.count, 2);
`endif
    step();
    bus.rdReq = 1'b1; bus.rdAdd = 32'h840; exp_rd(1, 6000); step();
    bus.rdAdd = 32'h844; exp_rd(0, 0); step();
    bus.rdAdd = 32'h842; exp_rd(1, 6000); step();
    bus.rdReq = 1'b0;

    // Same-cycle write and lookup forward the write data
    bus.wrReq = 1'b1; bus.wrAdd = 32'h100; bus.wrData = 7;
    bus.rdReq = 1'b1; bus.rdAdd = 32'h100;
    exp_rd(1, 7);
    exp_mem(32'h100, 7);
    neg();
    chk("t4_wrAck", bus.wrAck, 1);
    step();
    bus.wrReq = 1'b0; bus.rdReq = 1'b0;
    step();
    drain();

    // Entry popped in the lookup cycle still matches
    exp_mem(32'h300, 9);
    wr(32'h300, 9);
    step();
    bus.memReady = 1'b1; bus.rdReq = 1'b1; bus.rdAdd = 32'h300;
    exp_rd(1, 9);
    step();
    bus.memReady = 1'b0; bus.rdReq = 1'b0;
    neg();
    chk("t5_count", bus.count, 0);
    chk("t5_empty", bus.empty, 1);
    step();

    // Coalescing around a draining head
    exp_mem(32'h500, 1);
    wr(32'h500, 1);
    step();
`ifdef WB_COALESCE_EN
    exp_mem(32'h200, 2);
    exp_mem(32'h500, 7);
    exp_mem(32'h600, 9);
    wr(32'h200, 1);
    wr(32'h200, 2);
    wr(32'h500, 7);
    neg();
    chk("t6_count", bus.count, 3);
    wr(32'h600, 8);
    neg();
    chk("t6_full", bus.full, 1);
    bus.wrReq = 1'b1; bus.wrAdd = 32'h600; bus.wrData = 9;
    neg();
    chk("t6_coal_full_ack", bus.wrAck, 1);
`else
    exp_mem(32'h200, 1);
    exp_mem(32'h200, 2);
    exp_mem(32'h500, 7);
    wr(32'h200, 1);
    wr(32'h200, 2);
    wr(32'h500, 7);
    neg();
    chk("t6_count", bus.count, 4);
    chk("t6_full", bus.full, 1);
    bus.wrReq = 1'b1; bus.wrAdd = 32'h600; bus.wrData = 8;
    neg();
    chk("t6_full_refuse", bus.wrAck, 0);
`endif
    step();
    bus.wrReq = 1'b0;
    neg();
    chk("t6_count_after", bus.count, 4);
    step();
    drain();

    // Reset in DRAIN discards pending writes
    wr(32'h700, 1);
    wr(32'h704, 2);
    wr(32'h708, 3);
    neg();
    chk("t7_count", bus.count, 3);
    chk("t7_memWe", bus.memWe, 1);
    x0 = n_xfer;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_memWe", bus.memWe, 0);
    chk("t7_rst_count", bus.count, 0);
    chk("t7_rst_empty", bus.empty, 1);
    chk("t7_rst_memAdd", bus.memAdd, 0);
    chk("t7_rst_memData", bus.memData, 0);
    step(); step();
    rst = 1'b0;
    step(); step();
    neg();
    chk("t7_post_memWe", bus.memWe, 0);
    chk("t7_post_empty", bus.empty, 1);
    chk("t7_no_pop", n_xfer, x0);
    step();
    bus.rdReq = 1'b1; bus.rdAdd = 32'h700; exp_rd(0, 0);
    step();
    bus.rdReq = 1'b0;
    step(); step();
    neg();
    chk("mem_q_empty", mem_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
